day_9_onehot_to_binary: RTL

//   Registered one-hot to binary encoder. It is the inverse of the binary-to-one-hot decoder.
//   It takes a ONE_HOT_W-bit code over a valid/ready handshake and returns its binary index one cycle later.

---
 rtl/day_9_onehot_to_binary.sv | 90 +++++++++
 1 files changed

// File: rtl/day_9_onehot_to_binary.sv
// Registered one-hot to binary encoder with malformed-code detection.
// A code accepted over valid/ready appears as a binary index one cycle later.
// All-zero and multi-bit codes are flagged and counted in a saturating counter.
module day_9_onehot_to_binary #(
  parameter int unsigned ONE_HOT_W = 16,
  parameter int unsigned BIN_W     = 4,
  parameter int unsigned CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [ONE_HOT_W-1:0] one_hot_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic [BIN_W-1:0]     bin_o,
  output logic                 zero_o,
  output logic                 multi_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [CNT_W-1:0]     err_cnt_o,
  input  logic                 err_clr_i
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [BIN_W-1:0]     enc_c;
  logic [ONE_HOT_W-1:0] shifted_c;
  logic                 zero_c;
  logic                 multi_c;
  logic                 accept_c;
  logic [CNT_W-1:0]     cnt_base_c;
  logic [CNT_W-1:0]     cnt_next_c;

  // The output register is free when empty or being drained this cycle.
  assign ready_o  = !valid_o || ready_i;
  assign accept_c = valid_i && ready_o;

  // Lowest set bit wins, so a multi-bit code still reports a usable index.
  always_comb begin
    enc_c     = '0;
    shifted_c = '0;
    for (int i = int'(ONE_HOT_W) - 1; i >= 0; i--) begin
      shifted_c = one_hot_i >> i;
      if (shifted_c[0]) begin
        enc_c = BIN_W'(i);
      end
    end
  end

  // Code classification: no bit set, or clearing the lowest set bit leaves others.
  always_comb begin
    zero_c  = (one_hot_i == '0);
    multi_c = |(one_hot_i & (one_hot_i - ONE_HOT_W'(1)));
  end

  // Clear first, then count the current invalid accept so it is never lost.
  always_comb begin
    cnt_base_c = err_clr_i ? '0 : err_cnt_o;
    cnt_next_c = cnt_base_c;
    if (accept_c && (zero_c || multi_c) && (cnt_base_c != CNT_MAX)) begin
      cnt_next_c = cnt_base_c + CNT_W'(1);
    end
  end

  // Output stage: load on accept, drop valid on a bare transfer, hold on stall.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bin_o   <= '0;
      zero_o  <= 1'b0;
      multi_o <= 1'b0;
      valid_o <= 1'b0;
    end else if (accept_c) begin
      bin_o   <= zero_c ? '0 : enc_c;
      zero_o  <= zero_c;
      multi_o <= multi_c;
      valid_o <= 1'b1;
    end else if (ready_i) begin
      valid_o <= 1'b0;
    end
  end

  // Saturating invalid-code counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_cnt_o <= '0;
    end else begin
      err_cnt_o <= cnt_next_c;
    end
  end

endmodule
